// File: rtl/uart_loopback_engine_if.sv
// Handshake bundle between the UART rx/tx ports and the loopback engine.
// The engine uses the slave modport; whatever drives the UART side uses master.
interface uart_loopback_engine_if #(
  parameter int DBIT = 8
);
  logic            rx_done_tick;
  logic [DBIT-1:0] r_data;
  logic            tx_ready;
  logic [1:0]      mode;
  logic [DBIT-1:0] w_data;
  logic            tx_start;
  logic            fifo_full;
  logic            fifo_empty;
  logic [7:0]      drop_count;
  logic [15:0]     tx_count;

  modport master (
    output rx_done_tick, r_data, tx_ready, mode,
    input  w_data, tx_start, fifo_full, fifo_empty, drop_count, tx_count
  );

  modport slave (
    input  rx_done_tick, r_data, tx_ready, mode,
    output w_data, tx_start, fifo_full, fifo_empty, drop_count, tx_count
  );
endinterface

// File: rtl/uart_loopback_engine.sv
// Transforms each received UART word by mode, buffers it in a FIFO and
// drains the FIFO into the UART transmitter via the tx_ready/tx_start handshake.
module uart_loopback_engine #(
  parameter int DBIT   = 8,
  parameter int ADDR_W = 4,
  parameter int INC    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  uart_loopback_engine_if.slave   bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [1:0] GUARD_LAST = 2'd3;

  typedef enum logic [1:0] {IDLE, START, BUSY_WAIT, DONE_WAIT} state_t;

  function automatic logic [DBIT-1:0] xform(input logic [1:0] m, input logic [DBIT-1:0] d);
    logic [DBIT-1:0] r;
    r = d;
    case (m)
      2'b00: r = d;
      2'b01: r = d + DBIT'(INC);
      2'b10: r = ~d;
      default: for (int i = 0; i < DBIT; i++) r[i] = d[DBIT-1-i];
    endcase
    return r;
  endfunction

  logic [DBIT-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, empty_q;
  logic [DBIT-1:0]   w_data_q;
  logic              tx_start_q;
  logic [7:0]        drop_q;
  logic [15:0]       tx_cnt_q;
  logic [1:0]        guard_q;
  state_t            state_q;
  logic              push, pop;

  // Full is judged on registered state, so a push while full is lost even if a pop frees a slot.
  always_comb begin
    push    = bus.rx_done_tick && !full_q;
    pop     = (state_q == IDLE) && !empty_q && bus.tx_ready;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= xform(bus.mode, bus.r_data);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      w_data_q   <= '0;
      tx_start_q <= 1'b0;
      drop_q     <= '0;
      tx_cnt_q   <= '0;
      guard_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == (ADDR_W+1)'(DEPTH));
      empty_q <= (count_d == '0);
      if (bus.rx_done_tick && full_q && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;

      tx_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            w_data_q   <= mem[rd_ptr_q];
            rd_ptr_q   <= rd_ptr_q + 1'b1;
            tx_start_q <= 1'b1;
            state_q    <= START;
          end
        end
        START: begin
          tx_cnt_q <= tx_cnt_q + 16'd1;
          guard_q  <= '0;
          state_q  <= BUSY_WAIT;
        end
        BUSY_WAIT: begin
          // A transmitter that never drops tx_ready missed the start; give up after 4 cycles.
          if (!bus.tx_ready)           state_q <= DONE_WAIT;
          else if (guard_q == GUARD_LAST) state_q <= IDLE;
          else                         guard_q <= guard_q + 2'd1;
        end
        DONE_WAIT: begin
          if (bus.tx_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.w_data     = w_data_q;
  assign bus.tx_start   = tx_start_q;
  assign bus.fifo_full  = full_q;
  assign bus.fifo_empty = empty_q;
  assign bus.drop_count = drop_q;
  assign bus.tx_count   = tx_cnt_q;

endmodule

// File: tb/tb_uart_loopback_engine.sv
// Directed bench for uart_loopback_engine: stimulus pushes expected words into a
// scoreboard queue, a monitor pops and compares on every tx_start.
module tb_uart_loopback_engine;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_loopback_engine_if #(.DBIT(8)) bus ();

  uart_loopback_engine #(.DBIT(8), .ADDR_W(4), .INC(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] sb [$];
  int checks = 0;
  int passed = 0;
  int nstart = 0;
  int cyc = 0;
  int last_start = 0;
  int gap = 0;
  bit auto_tx = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every tx_start must match the oldest expected word.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset && bus.tx_start) begin
        nstart++;
        gap = cyc - last_start;
        last_start = cyc;
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_tx_start: w_data %0h with no word expected", bus.w_data);
        end else begin
          chk("w_data_order", {24'd0, bus.w_data}, {24'd0, sb.pop_front()});
        end
      end
    end
  end

  // Transmitter model: busy for 3 cycles after each accepted start.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (auto_tx && bus.tx_start) begin
        bus.tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.tx_ready = 1'b1;
      end
    end
  end

  task automatic send(input logic [1:0] m, input logic [7:0] d, input bit expect_it, input logic [7:0] exp);
    bus.mode = m;
    bus.r_data = d;
    bus.rx_done_tick = 1'b1;
    if (expect_it) sb.push_back(exp);
    @(negedge clk);
    bus.rx_done_tick = 1'b0;
  endtask

  task automatic do_reset();
    bus.rx_done_tick = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    sb.delete();
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || !bus.fifo_empty || !bus.tx_ready) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (8) @(negedge clk);
    if (n >= 3000) begin
      checks++;
      $display("FAIL %s_timeout: %0d words still expected after %0d cycles", name, sb.size(), n);
    end
  endtask

  initial begin
    int snap;
    bus.rx_done_tick = 1'b0;
    bus.r_data = '0;
    bus.mode = 2'b00;
    bus.tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    // Reset with data queued
    send(2'b00, 8'hAA, 0, 8'h00);
    send(2'b00, 8'hBB, 0, 8'h00);
    send(2'b00, 8'hCC, 0, 8'h00);
    chk("queued_not_empty", {31'd0, bus.fifo_empty}, 32'd0);
    do_reset();
    chk("rst_w_data", {24'd0, bus.w_data}, 32'd0);
    chk("rst_tx_start", {31'd0, bus.tx_start}, 32'd0);
    chk("rst_fifo_empty", {31'd0, bus.fifo_empty}, 32'd1);
    chk("rst_fifo_full", {31'd0, bus.fifo_full}, 32'd0);
    chk("rst_drop_count", {24'd0, bus.drop_count}, 32'd0);
    chk("rst_tx_count", {16'd0, bus.tx_count}, 32'd0);
    snap = nstart;
    bus.tx_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_no_start_20", nstart, snap);
    chk("rst_still_empty", {31'd0, bus.fifo_empty}, 32'd1);

    // Latency: tx_start two cycles after rx tick
    send(2'b01, 8'h41, 1, 8'h42);
    chk("lat_empty_n1", {31'd0, bus.fifo_empty}, 32'd0);
    chk("lat_no_start_n1", {31'd0, bus.tx_start}, 32'd0);
    @(negedge clk);
    chk("lat_start_n2", {31'd0, bus.tx_start}, 32'd1);
    chk("lat_w_data", {24'd0, bus.w_data}, 32'h42);
    drain("lat");
    send(2'b01, 8'hFF, 1, 8'h00);
    drain("inc_wrap");
    chk("inc_wrap_w_data", {24'd0, bus.w_data}, 32'h00);

    // Modes 00/10/11
    do_reset();
    send(2'b00, 8'h1E, 1, 8'h1E);
    send(2'b10, 8'h1E, 1, 8'hE1);
    send(2'b11, 8'h1E, 1, 8'h78);
    drain("modes");
    chk("modes_tx_count", {16'd0, bus.tx_count}, 32'd3);

    // Overflow with transmitter stalled
    do_reset();
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      send(2'b00, 8'(8'h30 + i), (i < 16), 8'(8'h30 + i));
      if (i == 14) chk("not_full_15", {31'd0, bus.fifo_full}, 32'd0);
      if (i == 15) chk("full_16", {31'd0, bus.fifo_full}, 32'd1);
    end
    chk("ovf_drop_count", {24'd0, bus.drop_count}, 32'd4);
    bus.tx_ready = 1'b1;
    drain("ovf");
    chk("ovf_empty", {31'd0, bus.fifo_empty}, 32'd1);
    chk("ovf_tx_count", {16'd0, bus.tx_count}, 32'd16);

    // Push while full coinciding with a pop is still dropped
    do_reset();
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(2'b10, 8'(i), 1, ~8'(i));
    bus.tx_ready = 1'b1;
    send(2'b00, 8'h99, 0, 8'h00);
    chk("popfull_drop", {24'd0, bus.drop_count}, 32'd1);
    chk("popfull_not_full", {31'd0, bus.fifo_full}, 32'd0);
    drain("popfull");
    chk("popfull_tx_count", {16'd0, bus.tx_count}, 32'd16);
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(2'b00, 8'(8'h80 + i), 1, 8'(8'h80 + i));
    for (int i = 0; i < 300; i++) send(2'b00, 8'h55, 0, 8'h00);
    chk("drop_saturate", {24'd0, bus.drop_count}, 32'd255);
    chk("sat_full", {31'd0, bus.fifo_full}, 32'd1);
    bus.tx_ready = 1'b1;
    drain("sat");
    chk("sat_tx_count", {16'd0, bus.tx_count}, 32'd32);

    // Lost-start guard: transmitter never drops tx_ready
    do_reset();
    auto_tx = 1'b0;
    bus.tx_ready = 1'b1;
    snap = nstart;
    send(2'b00, 8'h5A, 1, 8'h5A);
    send(2'b00, 8'hC3, 1, 8'hC3);
    repeat (30) @(negedge clk);
    chk("guard_starts", nstart - snap, 32'd2);
    chk("guard_gap", gap, 32'd6);
    chk("guard_tx_count", {16'd0, bus.tx_count}, 32'd2);
    chk("guard_sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
